// File: rtl/eqchk_pkg.sv
// Shared types and helpers for the stream equality checker.
package eqchk_pkg;

  // Widest operand that eval_eq can evaluate; narrower operands are
  // zero-extended, and padding bits are known and equal, so they never
  // change the result.
  localparam int MAX_W = 64;

  // The five results produced for each operand pair.
  typedef struct packed {
    logic eq;
    logic ne;
    logic eq_x;
    logic ceq;
    logic cne;
  } eq_result_t;

  // Which statistics counter an accepted pair belongs to.
  typedef enum logic [1:0] {
    CLS_MATCH    = 2'd0,
    CLS_MISMATCH = 2'd1,
    CLS_UNKNOWN  = 2'd2
  } result_class_t;

  // Four-state equality over two-state value/X-flag pairs.
  // A definite differing bit dominates any unknown bit for the logical result.
  // The case result compares the X flags themselves and ignores value bits
  // under X.
  function automatic eq_result_t eval_eq(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] a_x,
                                         input logic [MAX_W-1:0] b,
                                         input logic [MAX_W-1:0] b_x);
    eq_result_t r;
    logic any_diff;
    logic any_unk;
    logic all_match;
    logic known;
    any_diff  = 1'b0;
    any_unk   = 1'b0;
    all_match = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      known = !a_x[i] && !b_x[i];
      if (known && (a[i] != b[i])) any_diff = 1'b1;
      if (!known) any_unk = 1'b1;
      if (!((a_x[i] == b_x[i]) && (a_x[i] || (a[i] == b[i])))) all_match = 1'b0;
    end
    r.eq   = !any_diff && !any_unk;
    r.ne   = any_diff;
    r.eq_x = !any_diff && any_unk;
    r.ceq  = all_match;
    r.cne  = !all_match;
    return r;
  endfunction

  // Maps a result to exactly one counter class.
  function automatic result_class_t classify(input eq_result_t r);
    if (r.ne)        return CLS_MISMATCH;
    else if (r.eq_x) return CLS_UNKNOWN;
    else             return CLS_MATCH;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int w);
    logic [63:0] max;
    max = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (val >= max) ? max : (val + 64'd1);
  endfunction

endpackage

// File: rtl/eq_compare_core.sv
// Purely combinational per-bit evaluation of one operand pair.
module eq_compare_core
  import eqchk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] b_x,
  output eq_result_t       res
);

  // Operands are widened to the evaluator width; the padding is neutral.
  assign res = eval_eq(MAX_W'(a), MAX_W'(a_x), MAX_W'(b), MAX_W'(b_x));

endmodule

// File: rtl/stream_equality_checker.sv
// Registered, handshaked equality checker with saturating statistics
// and a sticky record of the first case mismatch.
module stream_equality_checker
  import eqchk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] b_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             ne,
  output logic             eq_x,
  output logic             ceq,
  output logic             cne,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] unknown_cnt,
  output logic             mm_seen,
  output logic [CNT_W-1:0] first_mm_idx
);

  eq_result_t    cur_res;
  eq_result_t    res_q;
  result_class_t cur_cls;
  logic          accept;
  logic          valid_q;
  logic [CNT_W-1:0] tx_idx;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] mismatch_q;
  logic [CNT_W-1:0] unknown_q;
  logic [CNT_W-1:0] first_q;
  logic          seen_q;

  eq_compare_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .a_x (a_x),
    .b   (b),
    .b_x (b_x),
    .res (cur_res)
  );

  // The single output slot can take a new pair when empty or draining this cycle.
  always_comb begin
    in_ready = !valid_q || out_ready;
    accept   = in_valid && in_ready;
    cur_cls  = classify(cur_res);
  end

  // One-entry output register; results only change on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= cur_res;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Statistics and sticky status; clr overrides a coincident accept.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tx_idx     <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      unknown_q  <= '0;
      seen_q     <= 1'b0;
      first_q    <= '0;
    end else if (accept) begin
      tx_idx <= CNT_W'(sat_inc(64'(tx_idx), CNT_W));
      case (cur_cls)
        CLS_MATCH:    match_q    <= CNT_W'(sat_inc(64'(match_q), CNT_W));
        CLS_MISMATCH: mismatch_q <= CNT_W'(sat_inc(64'(mismatch_q), CNT_W));
        CLS_UNKNOWN:  unknown_q  <= CNT_W'(sat_inc(64'(unknown_q), CNT_W));
        default:      unknown_q  <= unknown_q;
      endcase
      if (!cur_res.ceq && !seen_q) begin
        seen_q  <= 1'b1;
        first_q <= tx_idx;
      end
    end
  end

  assign out_valid    = valid_q;
  assign eq           = res_q.eq;
  assign ne           = res_q.ne;
  assign eq_x         = res_q.eq_x;
  assign ceq          = res_q.ceq;
  assign cne          = res_q.cne;
  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign unknown_cnt  = unknown_q;
  assign mm_seen      = seen_q;
  assign first_mm_idx = first_q;

endmodule

// File: tb/tb_stream_equality_checker.sv
// Directed self-checking bench for stream_equality_checker (WIDTH=4, CNT_W=2).
module tb_stream_equality_checker;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, a_x, b_x;
  logic             out_valid;
  logic             out_ready;
  logic             eq, ne, eq_x, ceq, cne;
  logic [CNT_W-1:0] match_cnt, mismatch_cnt, unknown_cnt, first_mm_idx;
  logic             mm_seen;

  int total = 0;
  int bad   = 0;

  stream_equality_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .a_x          (a_x),
    .b_x          (b_x),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .eq           (eq),
    .ne           (ne),
    .eq_x         (eq_x),
    .ceq          (ceq),
    .cne          (cne),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .unknown_cnt  (unknown_cnt),
    .mm_seen      (mm_seen),
    .first_mm_idx (first_mm_idx)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s differs", tag);
    end
  endtask

  // Compares the handshake flag and all five result bits.
  task automatic checkResult(input string tag, input logic ov, input logic e, input logic n,
                             input logic ex, input logic ce, input logic cn);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    checkOutput({tag, ".eq"},        32'(eq),        32'(e));
    checkOutput({tag, ".ne"},        32'(ne),        32'(n));
    checkOutput({tag, ".eq_x"},      32'(eq_x),      32'(ex));
    checkOutput({tag, ".ceq"},       32'(ceq),       32'(ce));
    checkOutput({tag, ".cne"},       32'(cne),       32'(cn));
  endtask

  // Compares the statistics and sticky status.
  task automatic checkCounts(input string tag, input int m, input int mm, input int u,
                             input logic seen, input int first);
    checkOutput({tag, ".match_cnt"},    32'(match_cnt),    32'(m));
    checkOutput({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(mm));
    checkOutput({tag, ".unknown_cnt"},  32'(unknown_cnt),  32'(u));
    checkOutput({tag, ".mm_seen"},      32'(mm_seen),      32'(seen));
    checkOutput({tag, ".first_mm_idx"}, 32'(first_mm_idx), 32'(first));
  endtask

  // Drives one operand pair without advancing time.
  task automatic applyStimulus(input logic v, input logic [3:0] va, input logic [3:0] vax,
                               input logic [3:0] vb, input logic [3:0] vbx);
    in_valid = v;
    a        = va;
    a_x      = vax;
    b        = vb;
    b_x      = vbx;
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); tick();
    rst = 1'b0;
    checkResult("reset", 0, 0, 0, 0, 0, 0);
    checkCounts("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);

    // Exact match, index 0.
    applyStimulus(1'b1, 4'b1010, 4'b0000, 4'b1010, 4'b0000);
    tick();
    checkResult("match", 1, 1, 0, 0, 1, 0);
    checkCounts("match", 1, 0, 0, 0, 0);

    // Definite mismatch, index 1.
    applyStimulus(1'b1, 4'b1010, 4'b0000, 4'b0101, 4'b0000);
    tick();
    checkResult("mismatch", 1, 0, 1, 0, 0, 1);
    checkCounts("mismatch", 1, 1, 0, 1, 1);

    // 10x1 vs 10x1 with differing value bits under the X.
    applyStimulus(1'b1, 4'b1001, 4'b0010, 4'b1011, 4'b0010);
    tick();
    checkResult("bothx", 1, 0, 0, 1, 1, 0);
    checkCounts("bothx", 1, 1, 1, 1, 1);

    // 10x1 vs 1011: logically unknown, case mismatch, sticky index kept.
    applyStimulus(1'b1, 4'b1001, 4'b0010, 4'b1011, 4'b0000);
    tick();
    checkResult("onex", 1, 0, 0, 1, 0, 1);
    checkCounts("onex", 1, 1, 2, 1, 1);

    // Back-pressure: next pair waits, held result and counters frozen.
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #1;
    checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp.in_ready_hold", 32'(in_ready), 32'd0);
      checkResult("bp.hold", 1, 0, 0, 1, 0, 1);
      checkCounts("bp.hold", 1, 1, 2, 1, 1);
    end

    // Release: waiting pair then one more, each exactly once.
    out_ready = 1'b1;
    #1;
    checkOutput("rel.in_ready", 32'(in_ready), 32'd1);
    tick();
    checkResult("rel.first", 1, 1, 0, 0, 1, 0);
    checkCounts("rel.first", 2, 1, 2, 1, 1);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0111, 4'b0000);
    tick();
    checkResult("rel.second", 1, 0, 1, 0, 0, 1);
    checkCounts("rel.second", 2, 2, 2, 1, 1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("drain.out_valid", 32'(out_valid), 32'd0);
    checkCounts("drain", 2, 2, 2, 1, 1);

    // Idle clear.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkCounts("clr.idle", 0, 0, 0, 0, 0);
    checkOutput("clr.idle.out_valid", 32'(out_valid), 32'd0);

    // Five matches saturate a 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'(i), 4'b0000, 4'(i), 4'b0000);
      tick();
      checkOutput("sat.match_cnt", 32'(match_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      checkOutput("sat.eq", 32'(eq), 32'd1);
    end

    // Clear coinciding with a mismatching accept: result kept, status cleared.
    clr = 1'b1;
    applyStimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick();
    clr = 1'b0;
    checkResult("clr.acc", 1, 0, 1, 0, 0, 1);
    checkCounts("clr.acc", 0, 0, 0, 0, 0);

    // Index restarted at 0 after the clear.
    applyStimulus(1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    tick();
    checkResult("postclr", 1, 0, 0, 1, 0, 1);
    checkCounts("postclr", 0, 0, 1, 1, 0);

    // Reset mid-stream with a pair offered.
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1100, 4'b0000, 4'b1100, 4'b0000);
    tick();
    checkResult("midrst", 0, 0, 0, 0, 0, 0);
    checkCounts("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    #1;
    checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_equality_checker.md
# stream_equality_checker

Parametrised, registered successor to the 4-bit equality-operator block. It compares two WIDTH-bit operand streams under a valid/ready handshake and produces four results per accepted pair: logical equality (`==`) and inequality (`!=`) with explicit unknown flags, and case equality (`===`) and inequality (`!==`). Because hardware is 2-state, per-bit X-flag inputs carry the 4-state semantics. It also keeps saturating statistics counters and a sticky first-mismatch index, and sits in the verification/self-check datapath between a stimulus source and a scoreboard.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥1)
- CNT_W, 16, width of statistics counters and transaction index

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous clear of counters and sticky status only
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- a, b  in  WIDTH  operand values
- a_x, b_x  in  WIDTH  per-bit unknown flags (1 = bit is X; value bit ignored)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- eq, ne  out  1  logical equality / inequality (0 when unknown)
- eq_x  out  1  logical result unknown (applies to eq and ne)
- ceq, cne  out  1  case equality / inequality
- match_cnt, mismatch_cnt, unknown_cnt  out  CNT_W  saturating counts of accepted pairs
- mm_seen  out  1  sticky: at least one case mismatch since reset/clr
- first_mm_idx  out  CNT_W  transaction index of first case mismatch

## Operation
- Per bit i: known_i = !a_x[i] & !b_x[i]; diff_i = known_i & (a[i]^b[i]).
- Logical: if any diff_i → eq=0, ne=1, eq_x=0. Else if any !known_i → eq=0, ne=0, eq_x=1. Else eq=1, ne=0, eq_x=0.
- Case: bit matches iff a_x[i]==b_x[i] and (a_x[i] or a[i]==b[i]). ceq = AND of all bit matches; cne = !ceq; never unknown.
- Accept = in_valid & in_ready. On accept:
  - results are registered;
  - tx_idx increments, saturating at 2^CNT_W−1;
  - exactly one of match_cnt (eq=1), mismatch_cnt (ne=1) or unknown_cnt (eq_x=1) increments, saturating;
  - if ceq=0 and !mm_seen, then mm_seen←1 and first_mm_idx←current tx_idx (pre-increment).
- Output stage: one-entry register. in_ready = !out_valid | out_ready. out_valid sets on accept and clears on out_ready without a new accept. Results hold stable while out_valid & !out_ready.
- clr: zeroes counters, tx_idx, mm_seen and first_mm_idx. It does not touch out_valid or the result registers. If clr coincides with an accept, clr wins for the counters and status, and the result is still registered.
- Reset values: out_valid=0, eq=ne=eq_x=ceq=cne=0, all counters=0, tx_idx=0, mm_seen=0, first_mm_idx=0. in_ready=1 from the first cycle after reset.

## Timing
- Latency is 1 cycle: a pair accepted at edge N is presented with out_valid=1 after edge N.
- Full throughput (one pair per cycle) while out_ready=1.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready=0 combinationally and no accept occurs.
- Counter and sticky updates are visible the cycle after accept, aligned with out_valid.
- Reset asserted mid-stream drops any held result (out_valid=0 the next cycle) with no partial counter update.
- No combinational path from in_valid, a or b to any output. The only combinational path is out_ready → in_ready.

## Structure
- Package `eqchk_pkg`:
  - `eq_result_t` struct {eq, ne, eq_x, ceq, cne};
  - function `eval_eq(a, a_x, b, b_x)` returning `eq_result_t` (width via parameterised wrapper or unsized loop);
  - saturating-increment helper.
- Sub-module `eq_compare_core`: purely combinational per-bit evaluation, parameter WIDTH.
- Top level: handshake register, counters and sticky logic.

## Test plan
- WIDTH=4. a=1010, b=1010, no X → eq=1, ne=0, eq_x=0, ceq=1, cne=0; match_cnt=1.
- a=1010, b=0101 → eq=0, ne=1, eq_x=0, ceq=0, cne=1; mismatch_cnt=1, mm_seen=1, first_mm_idx=1 (after the pair above).
- a=1001 with a_x=0010 (10x1), b=10x1 → eq=0, ne=0, eq_x=1, ceq=1; unknown_cnt=1.
- a=10x1, b=1011 → eq_x=1, ceq=0, cne=1; first_mm_idx unchanged.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, counters frozen. Release → streaming resumes with one result per cycle and no loss or duplication.
- CNT_W=2, 5 matching pairs → match_cnt saturates at 3. Pulse clr during an accept → counters=0 next cycle, result still delivered. Assert rst mid-stream → all outputs at reset values next cycle.
